// File: rtl/tanh_region_dispatch.sv
// tanh_region_dispatch
// Pairs each accepted float32 sample with the region code that the classifier
// produces one cycle later. Saturation and linear results are built locally.
// Hyperbolic samples go to an external in-order core. All results leave in
// input order through a DEPTH-entry reorder FIFO.
//
// Optional build macro: TANH_ODD_SYM_EN
//   When defined, the core receives |x| and the stored input sign is folded
//   back into the core result (tanh is odd).
//
// Ports:
//   clock, resetn               clock and synchronous active-low reset
//   valid_in, in_ready, x_in    sample input handshake
//   region_in                   classifier code for the staged sample
//                               (01 sat, 10 linear, 00 hyperbolic, 11 invalid)
//   hc_req_valid/ready, hc_x    request to the hyperbolic core
//   hc_resp_valid, hc_resp_y    in-order core response, no backpressure
//   y_valid/ready, y, y_region  ordered result output
//   drop_count                  saturating count of region-11 drops
module tanh_region_dispatch #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             valid_in,
    output logic             in_ready,
    input  logic [31:0]      x_in,
    input  logic [1:0]       region_in,
    output logic             hc_req_valid,
    input  logic             hc_req_ready,
    output logic [31:0]      hc_x,
    input  logic             hc_resp_valid,
    input  logic [31:0]      hc_resp_y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [31:0]      y,
    output logic [1:0]       y_region,
    output logic [CNT_W-1:0] drop_count
);

    localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_BITS = PTR_W + 1;

    localparam logic [1:0]  REG_HYP = 2'b00;
    localparam logic [1:0]  REG_SAT = 2'b01;
    localparam logic [1:0]  REG_LIN = 2'b10;
    localparam logic [1:0]  REG_INV = 2'b11;

    localparam logic [31:0] POS_ONE = 32'h3F80_0000;
    localparam logic [31:0] NEG_ONE = 32'hBF80_0000;

    // Stage register
    logic [31:0]         stage_x_q;
    logic                stage_v_q;
    logic                stage_first_q;
    logic [1:0]          stage_region_q;

    // Reorder FIFO storage
    logic [31:0]         data_q   [DEPTH];
    logic [1:0]          region_q [DEPTH];
    logic [DEPTH-1:0]    rdy_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_BITS-1:0] count_q;
`ifdef TANH_ODD_SYM_EN
    logic [DEPTH-1:0]    sign_q;
`endif

    // Indices of pending entries in request order; its head is the pending pointer
    logic [PTR_W-1:0]    pidx_q [DEPTH];
    logic [PTR_W-1:0]    pwr_q;
    logic [PTR_W-1:0]    prd_q;
    logic [CNT_BITS-1:0] pcnt_q;

    logic [CNT_W-1:0]    drop_q;

    logic [1:0]          region_c;
    logic                space_c;
    logic                stage_done_c;
    logic                accept_c;
    logic                wr_en_c;
    logic                drop_c;
    logic                req_hs_c;
    logic                pop_c;
    logic                fill_c;
    logic [PTR_W-1:0]    fill_idx_c;
    logic [31:0]         wr_data_c;
    logic [31:0]         fill_data_c;

    // Stage completion, handshakes and FIFO control
    always_comb begin
        region_c = stage_region_q;
        if (stage_first_q) begin
            region_c = region_in;
        end
        space_c      = (count_q < CNT_BITS'(DEPTH));
        hc_req_valid = stage_v_q && (region_c == REG_HYP) && space_c;
        stage_done_c = stage_v_q && ((region_c == REG_INV) ||
                       (space_c && ((region_c != REG_HYP) || hc_req_ready)));
        in_ready     = !stage_v_q || stage_done_c;
        accept_c     = valid_in && in_ready;
        wr_en_c      = stage_done_c && (region_c != REG_INV);
        drop_c       = stage_done_c && (region_c == REG_INV);
        req_hs_c     = wr_en_c && (region_c == REG_HYP);
        y_valid      = (count_q != '0) && rdy_q[rd_ptr_q];
        pop_c        = y_valid && y_ready;
        fill_c       = hc_resp_valid && (pcnt_q != '0);
        fill_idx_c   = pidx_q[prd_q];
        case (region_c)
            REG_SAT: wr_data_c = stage_x_q[31] ? NEG_ONE : POS_ONE;
            REG_LIN: wr_data_c = stage_x_q;
            default: wr_data_c = '0;
        endcase
    end

`ifdef TANH_ODD_SYM_EN
    // Core only sees |x|; the sign is reapplied when the result comes back
    assign hc_x        = {1'b0, stage_x_q[30:0]};
    assign fill_data_c = {sign_q[fill_idx_c] ^ hc_resp_y[31], hc_resp_y[30:0]};
`else
    assign hc_x        = stage_x_q;
    assign fill_data_c = hc_resp_y;
`endif

    assign y          = data_q[rd_ptr_q];
    assign y_region   = region_q[rd_ptr_q];
    assign drop_count = drop_q;

    // Stage register; region is latched if the stage stalls on its first cycle
    always_ff @(posedge clock) begin
        if (!resetn) begin
            stage_x_q      <= '0;
            stage_v_q      <= 1'b0;
            stage_first_q  <= 1'b0;
            stage_region_q <= '0;
        end else if (accept_c) begin
            stage_x_q     <= x_in;
            stage_v_q     <= 1'b1;
            stage_first_q <= 1'b1;
        end else if (stage_done_c) begin
            stage_v_q     <= 1'b0;
            stage_first_q <= 1'b0;
        end else if (stage_v_q && stage_first_q) begin
            stage_region_q <= region_in;
            stage_first_q  <= 1'b0;
        end
    end

    // Reorder FIFO: stage writes, response fills and head pops
    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i]   <= '0;
                region_q[i] <= '0;
                pidx_q[i]   <= '0;
            end
            rdy_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pwr_q    <= '0;
            prd_q    <= '0;
            pcnt_q   <= '0;
`ifdef TANH_ODD_SYM_EN
            sign_q   <= '0;
`endif
        end else begin
            if (wr_en_c) begin
                data_q[wr_ptr_q]   <= wr_data_c;
                region_q[wr_ptr_q] <= region_c;
                rdy_q[wr_ptr_q]    <= (region_c != REG_HYP);
`ifdef TANH_ODD_SYM_EN
                sign_q[wr_ptr_q]   <= stage_x_q[31];
`endif
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (req_hs_c) begin
                pidx_q[pwr_q] <= wr_ptr_q;
                pwr_q         <= pwr_q + PTR_W'(1);
            end
            // A fill always targets an older, already allocated entry
            if (fill_c) begin
                data_q[fill_idx_c] <= fill_data_c;
                rdy_q[fill_idx_c]  <= 1'b1;
                prd_q              <= prd_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_BITS'(wr_en_c) - CNT_BITS'(pop_c);
            pcnt_q  <= pcnt_q + CNT_BITS'(req_hs_c) - CNT_BITS'(fill_c);
        end
    end

    // Saturating drop counter
    always_ff @(posedge clock) begin
        if (!resetn) begin
            drop_q <= '0;
        end else if (drop_c && (drop_q != '1)) begin
            drop_q <= drop_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_tanh_region_dispatch.sv
// Randomized and directed bench for tanh_region_dispatch. The bench plays the
// classifier (region one cycle after acceptance, noise otherwise), the
// in-order hyperbolic core, and a queue-based reference of expected results.
module tb_tanh_region_dispatch;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 2;

    logic             clock = 1'b0;
    logic             resetn;
    logic             valid_in;
    logic             in_ready;
    logic [31:0]      x_in;
    logic [1:0]       region_in = 2'b00;
    logic             hc_req_valid;
    logic             hc_req_ready = 1'b1;
    logic [31:0]      hc_x;
    logic             hc_resp_valid = 1'b0;
    logic [31:0]      hc_resp_y = 32'h0;
    logic             y_valid;
    logic             y_ready = 1'b1;
    logic [31:0]      y;
    logic [1:0]       y_region;
    logic [CNT_W-1:0] drop_count;

    tanh_region_dispatch #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .resetn(resetn),
        .valid_in(valid_in), .in_ready(in_ready), .x_in(x_in), .region_in(region_in),
        .hc_req_valid(hc_req_valid), .hc_req_ready(hc_req_ready), .hc_x(hc_x),
        .hc_resp_valid(hc_resp_valid), .hc_resp_y(hc_resp_y),
        .y_valid(y_valid), .y_ready(y_ready), .y(y), .y_region(y_region),
        .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    int          vectors = 0;
    int          miscompares = 0;
    int unsigned cyc = 0;

    logic [31:0] exp_y[$];
    logic [1:0]  exp_r[$];
    logic [31:0] exp_op[$];
    logic [31:0] obs_y[$];
    logic [1:0]  obs_r[$];
    logic [31:0] obs_op[$];
    int unsigned exp_drop = 0;

    int unsigned resp_due[$];
    logic [31:0] resp_val[$];
    int unsigned core_lat = 3;
    bit          core_rand = 1'b0;
    int unsigned last_due = 0;
    int unsigned due;

    bit          rand_rdy = 1'b0;
    logic        yr_set = 1'b1;
    logic        hr_set = 1'b1;
    logic [1:0]  cur_region = 2'b00;
    bit          acc_seen = 1'b0;
    logic [1:0]  acc_region = 2'b00;

    // Stand-in for the core's tanh evaluation: any fixed mapping works
    function automatic logic [31:0] core_fn(input logic [31:0] a);
        if (a == 32'h3F00_0000) return 32'h3EEC_9A9E;
        return {a[0] ^ a[31], a[30:0] ^ 31'h1A2B_3C4D};
    endfunction

    function automatic logic [31:0] ref_op(input logic [31:0] x);
`ifdef TANH_ODD_SYM_EN
        return {1'b0, x[30:0]};
`else
        return x;
`endif
    endfunction

    function automatic logic [31:0] ref_hyp(input logic [31:0] x);
        logic [31:0] m;
        m = core_fn(ref_op(x));
`ifdef TANH_ODD_SYM_EN
        return {x[31] ^ m[31], m[30:0]};
`else
        return m;
`endif
    endfunction

    // Negedge observer: classifier bookkeeping, core requests, output pops
    always @(negedge clock) begin
        if (!resetn) begin
            resp_due.delete();
            resp_val.delete();
            acc_seen = 1'b0;
        end else begin
            acc_seen   = valid_in && in_ready;
            acc_region = cur_region;
            if (hc_req_valid && hc_req_ready) begin
                obs_op.push_back(hc_x);
                due = cyc + (core_rand ? $urandom_range(1, 8) : core_lat);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                resp_due.push_back(due);
                resp_val.push_back(core_fn(hc_x));
            end
            if (y_valid && y_ready) begin
                obs_y.push_back(y);
                obs_r.push_back(y_region);
            end
        end
    end

    // Posedge driver: core responses, classifier output, ready signals
    always @(posedge clock) begin
        cyc = cyc + 1;
        #2;
        if (resp_due.size() != 0 && resp_due[0] <= cyc) begin
            hc_resp_valid = 1'b1;
            hc_resp_y     = resp_val.pop_front();
            void'(resp_due.pop_front());
        end else begin
            hc_resp_valid = 1'b0;
            hc_resp_y     = $urandom;
        end
        region_in    = acc_seen ? acc_region : 2'($urandom);
        y_ready      = rand_rdy ? 1'($urandom) : yr_set;
        hc_req_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : hr_set;
    end

    task automatic clear_model();
        exp_y.delete(); exp_r.delete(); exp_op.delete();
        obs_y.delete(); obs_r.delete(); obs_op.delete();
    endtask

    // Present one sample until accepted; updates the reference on acceptance
    task automatic send(input logic [31:0] x, input logic [1:0] r, output bit ok);
        bit acc;
        ok = 1'b0;
        valid_in = 1'b1; x_in = x; cur_region = r;
        for (int n = 0; n < 500; n++) begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock); #1;
            if (acc) begin ok = 1'b1; break; end
        end
        valid_in = 1'b0; x_in = $urandom;
        if (ok) begin
            case (r)
                2'b01: begin exp_y.push_back(x[31] ? 32'hBF80_0000 : 32'h3F80_0000); exp_r.push_back(r); end
                2'b10: begin exp_y.push_back(x); exp_r.push_back(r); end
                2'b00: begin exp_y.push_back(ref_hyp(x)); exp_r.push_back(r); exp_op.push_back(ref_op(x)); end
                default: if (exp_drop < (1 << CNT_W) - 1) exp_drop++;
            endcase
        end
    endtask

    task automatic drain(output bit ok);
        int n = 0;
        while ((obs_y.size() < exp_y.size() || resp_due.size() != 0) && n < 3000) begin
            @(posedge clock);
            n++;
        end
        repeat (4) @(posedge clock);
        #1;
        ok = (n < 3000);
    endtask

    task automatic do_reset();
        resetn = 1'b0; valid_in = 1'b0;
        @(negedge clock);
        @(posedge clock); #1;
        resetn = 1'b1;
        exp_drop = 0;
        clear_model();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clock);
        vectors += 6;
        if (y_valid !== 1'b0)      begin miscompares++; $display("FAIL reset y_valid got %0b want 0", y_valid); end
        if (hc_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset hc_req_valid got %0b want 0", hc_req_valid); end
        if (in_ready !== 1'b1)     begin miscompares++; $display("FAIL reset in_ready got %0b want 1", in_ready); end
        if (y !== 32'h0)           begin miscompares++; $display("FAIL reset y got %h want 0", y); end
        if (y_region !== 2'b00)    begin miscompares++; $display("FAIL reset y_region got %b want 00", y_region); end
        if (drop_count !== '0)     begin miscompares++; $display("FAIL reset drop_count got %0d want 0", drop_count); end
        @(posedge clock); #1;
    endtask

    task automatic test_saturation();
        bit ok, all_ok;
        yr_set = 1'b1; hr_set = 1'b1;
        send(32'h4120_0000, 2'b01, ok); all_ok = ok;
        @(negedge clock);
        vectors++;
        if (y_valid !== 1'b0) begin miscompares++; $display("FAIL sat_latency_n1 y_valid got %0b want 0", y_valid); end
        @(negedge clock);
        vectors += 2;
        if (y_valid !== 1'b1) begin miscompares++; $display("FAIL sat_latency_n2 y_valid got %0b want 1", y_valid); end
        if (y !== 32'h3F80_0000) begin miscompares++; $display("FAIL sat_pos y got %h want 3f800000", y); end
        @(posedge clock); #1;
        send(32'hC120_0000, 2'b01, ok); all_ok &= ok;
        drain(ok); all_ok &= ok;
        vectors += 2;
        if (all_ok !== 1'b1) begin miscompares++; $display("FAIL sat timeout got %0b want 1", all_ok); end
        if (obs_y.size() != exp_y.size()) begin miscompares++; $display("FAIL sat count got %0d want %0d", obs_y.size(), exp_y.size()); end
        for (int i = 0; i < exp_y.size() && i < obs_y.size(); i++) begin
            vectors++;
            if ({obs_r[i], obs_y[i]} !== {exp_r[i], exp_y[i]}) begin
                miscompares++; $display("FAIL sat y[%0d] got %b/%h want %b/%h", i, obs_r[i], obs_y[i], exp_r[i], exp_y[i]);
            end
        end
        clear_model();
    endtask

    task automatic test_linear_drop();
        bit ok, all_ok;
        send(32'h3C23_D70A, 2'b10, ok); all_ok = ok;
        send(32'h1234_5678, 2'b11, ok); all_ok &= ok;
        drain(ok); all_ok &= ok;
        vectors += 3;
        if (drop_count !== 2'd1) begin miscompares++; $display("FAIL drop_one got %0d want 1", drop_count); end
        if (all_ok !== 1'b1) begin miscompares++; $display("FAIL lin timeout got %0b want 1", all_ok); end
        if (obs_y.size() != exp_y.size()) begin miscompares++; $display("FAIL lin count got %0d want %0d", obs_y.size(), exp_y.size()); end
        for (int i = 0; i < exp_y.size() && i < obs_y.size(); i++) begin
            vectors++;
            if ({obs_r[i], obs_y[i]} !== {exp_r[i], exp_y[i]}) begin
                miscompares++; $display("FAIL lin y[%0d] got %b/%h want %b/%h", i, obs_r[i], obs_y[i], exp_r[i], exp_y[i]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            send($urandom, 2'b11, ok);
        end
        drain(ok);
        vectors++;
        if (drop_count !== 2'd3) begin miscompares++; $display("FAIL drop_sat got %0d want 3", drop_count); end
        clear_model();
    endtask

    task automatic test_hyperbolic();
        bit ok, all_ok;
        core_rand = 1'b0; core_lat = 5;
        send(32'h3F00_0000, 2'b00, ok); all_ok = ok;
        send(32'hBF00_0000, 2'b00, ok); all_ok &= ok;
        drain(ok); all_ok &= ok;
        vectors += 3;
        if (all_ok !== 1'b1) begin miscompares++; $display("FAIL hyp timeout got %0b want 1", all_ok); end
        if (obs_op.size() != exp_op.size()) begin miscompares++; $display("FAIL hyp req_count got %0d want %0d", obs_op.size(), exp_op.size()); end
        if (obs_y.size() != exp_y.size()) begin miscompares++; $display("FAIL hyp count got %0d want %0d", obs_y.size(), exp_y.size()); end
        for (int i = 0; i < exp_op.size() && i < obs_op.size(); i++) begin
            vectors++;
            if (obs_op[i] !== exp_op[i]) begin miscompares++; $display("FAIL hyp hc_x[%0d] got %h want %h", i, obs_op[i], exp_op[i]); end
        end
        for (int i = 0; i < exp_y.size() && i < obs_y.size(); i++) begin
            vectors++;
            if ({obs_r[i], obs_y[i]} !== {exp_r[i], exp_y[i]}) begin
                miscompares++; $display("FAIL hyp y[%0d] got %b/%h want %b/%h", i, obs_r[i], obs_y[i], exp_r[i], exp_y[i]);
            end
        end
        clear_model();
    endtask

    task automatic test_order();
        bit ok, all_ok;
        core_rand = 1'b0; core_lat = 6;
        send(32'h3F00_0000, 2'b00, ok); all_ok = ok;
        send(32'h3C23_D70A, 2'b10, ok); all_ok &= ok;
        send(32'h4120_0000, 2'b01, ok); all_ok &= ok;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            vectors++;
            if (y_valid !== 1'b0) begin miscompares++; $display("FAIL order_hold[%0d] y_valid got %0b want 0", k, y_valid); end
        end
        drain(ok); all_ok &= ok;
        vectors += 2;
        if (all_ok !== 1'b1) begin miscompares++; $display("FAIL order timeout got %0b want 1", all_ok); end
        if (obs_y.size() != exp_y.size()) begin miscompares++; $display("FAIL order count got %0d want %0d", obs_y.size(), exp_y.size()); end
        for (int i = 0; i < exp_y.size() && i < obs_y.size(); i++) begin
            vectors++;
            if ({obs_r[i], obs_y[i]} !== {exp_r[i], exp_y[i]}) begin
                miscompares++; $display("FAIL order y[%0d] got %b/%h want %b/%h", i, obs_r[i], obs_y[i], exp_r[i], exp_y[i]);
            end
        end
        clear_model();
    endtask

    task automatic test_backpressure();
        bit ok, all_ok;
        all_ok = 1'b1;
        core_rand = 1'b0; core_lat = 2;
        yr_set = 1'b0;
        for (int k = 0; k < DEPTH + 1; k++) begin
            send($urandom, 2'b10, ok); all_ok &= ok;
        end
        @(negedge clock);
        vectors += 2;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full in_ready got %0b want 0", in_ready); end
        if (y_valid !== 1'b1)  begin miscompares++; $display("FAIL bp_full y_valid got %0b want 1", y_valid); end
        yr_set = 1'b1;
        drain(ok); all_ok &= ok;
        hr_set = 1'b0;
        send($urandom, 2'b00, ok); all_ok &= ok;
        repeat (3) @(posedge clock);
        @(negedge clock);
        vectors += 2;
        if (in_ready !== 1'b0)     begin miscompares++; $display("FAIL bp_hc in_ready got %0b want 0", in_ready); end
        if (hc_req_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hc hc_req_valid got %0b want 1", hc_req_valid); end
        hr_set = 1'b1;
        drain(ok); all_ok &= ok;
        vectors += 3;
        if (all_ok !== 1'b1) begin miscompares++; $display("FAIL bp timeout got %0b want 1", all_ok); end
        if (obs_y.size() != exp_y.size()) begin miscompares++; $display("FAIL bp count got %0d want %0d", obs_y.size(), exp_y.size()); end
        if (obs_op.size() != exp_op.size()) begin miscompares++; $display("FAIL bp req_count got %0d want %0d", obs_op.size(), exp_op.size()); end
        for (int i = 0; i < exp_y.size() && i < obs_y.size(); i++) begin
            vectors++;
            if ({obs_r[i], obs_y[i]} !== {exp_r[i], exp_y[i]}) begin
                miscompares++; $display("FAIL bp y[%0d] got %b/%h want %b/%h", i, obs_r[i], obs_y[i], exp_r[i], exp_y[i]);
            end
        end
        clear_model();
    endtask

    task automatic test_random();
        bit ok, all_ok;
        all_ok = 1'b1;
        core_rand = 1'b1; rand_rdy = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) begin @(posedge clock); #1; end
            send($urandom, 2'($urandom), ok); all_ok &= ok;
        end
        drain(ok); all_ok &= ok;
        rand_rdy = 1'b0; core_rand = 1'b0;
        vectors += 4;
        if (all_ok !== 1'b1) begin miscompares++; $display("FAIL rand timeout got %0b want 1", all_ok); end
        if (obs_y.size() != exp_y.size()) begin miscompares++; $display("FAIL rand count got %0d want %0d", obs_y.size(), exp_y.size()); end
        if (obs_op.size() != exp_op.size()) begin miscompares++; $display("FAIL rand req_count got %0d want %0d", obs_op.size(), exp_op.size()); end
        if (drop_count !== CNT_W'(exp_drop)) begin miscompares++; $display("FAIL rand drop_count got %0d want %0d", drop_count, exp_drop); end
        for (int i = 0; i < exp_op.size() && i < obs_op.size(); i++) begin
            vectors++;
            if (obs_op[i] !== exp_op[i]) begin miscompares++; $display("FAIL rand hc_x[%0d] got %h want %h", i, obs_op[i], exp_op[i]); end
        end
        for (int i = 0; i < exp_y.size() && i < obs_y.size(); i++) begin
            vectors++;
            if ({obs_r[i], obs_y[i]} !== {exp_r[i], exp_y[i]}) begin
                miscompares++; $display("FAIL rand y[%0d] got %b/%h want %b/%h", i, obs_r[i], obs_y[i], exp_r[i], exp_y[i]);
            end
        end
        clear_model();
    endtask

    task automatic test_reset_mid();
        bit ok, all_ok;
        all_ok = 1'b1;
        core_lat = 20; yr_set = 1'b1; hr_set = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send($urandom, 2'b00, ok); all_ok &= ok;
        end
        send($urandom, 2'b10, ok); all_ok &= ok;
        send($urandom, 2'b11, ok); all_ok &= ok;
        do_reset();
        @(negedge clock);
        vectors += 3;
        if (y_valid !== 1'b0)  begin miscompares++; $display("FAIL mid_reset y_valid got %0b want 0", y_valid); end
        if (drop_count !== '0) begin miscompares++; $display("FAIL mid_reset drop_count got %0d want 0", drop_count); end
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_reset in_ready got %0b want 1", in_ready); end
        @(posedge clock); #1;
        core_lat = 3;
        send(32'h3C23_D70A, 2'b10, ok); all_ok &= ok;
        send(32'h3F00_0000, 2'b00, ok); all_ok &= ok;
        send(32'hC120_0000, 2'b01, ok); all_ok &= ok;
        drain(ok); all_ok &= ok;
        vectors += 2;
        if (all_ok !== 1'b1) begin miscompares++; $display("FAIL mid timeout got %0b want 1", all_ok); end
        if (obs_y.size() != exp_y.size()) begin miscompares++; $display("FAIL mid count got %0d want %0d", obs_y.size(), exp_y.size()); end
        for (int i = 0; i < exp_y.size() && i < obs_y.size(); i++) begin
            vectors++;
            if ({obs_r[i], obs_y[i]} !== {exp_r[i], exp_y[i]}) begin
                miscompares++; $display("FAIL mid y[%0d] got %b/%h want %b/%h", i, obs_r[i], obs_y[i], exp_r[i], exp_y[i]);
            end
        end
        clear_model();
    endtask

    initial begin
        resetn = 1'b0; valid_in = 1'b0; x_in = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        test_saturation();
        test_linear_drop();
        test_hyperbolic();
        test_order();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tanh_region_dispatch.md
Name: tanh_region_dispatch

Overview:
- Downstream consumer of the 2-bit tanh region code produced one cycle after each float32 x is presented to the region classifier.
- Aligns each x with its region code and produces saturation (±1.0) and linear (y = x) results directly.
- Sends hyperbolic-region samples to an external in-order hyperbolic core over a request/response interface.
- Returns all results in input order through a DEPTH-entry reorder FIFO with a valid/ready output.

Parameters:
DEPTH, 4, reorder FIFO entries; power of two, at least 2; bounds outstanding hyperbolic requests.
CNT_W, 8, width of the drop counter.

Ports:
clock  input  1  clock
resetn  input  1  synchronous active-low reset
valid_in  input  1  x_in valid
in_ready  output  1  block accepts x_in this cycle
x_in  input  32  IEEE-754 single-precision sample; also drives the classifier input
region_in  input  2  classifier output, valid one cycle after x_in is accepted: 01 = saturation, 10 = linear, 00 = hyperbolic, 11 = invalid
hc_req_valid  output  1  hyperbolic request valid
hc_req_ready  input  1  hyperbolic core accepts the request
hc_x  output  32  operand sent to the core
hc_resp_valid  input  1  core result valid; no backpressure; responses return in order
hc_resp_y  input  32  core result
y_valid  output  1  result valid
y_ready  input  1  consumer accepts the result
y  output  32  tanh result
y_region  output  2  region code of the result
drop_count  output  CNT_W  count of samples dropped for region 11; saturates at all-ones

Behaviour:
- Reset (clock edge with resetn=0): all of the following are cleared.
  - stage_v=0; FIFO empty; all pointers 0; drop_count=0.
  - Outputs after reset: y_valid=0, hc_req_valid=0, in_ready=1, y=0, y_region=0.
  - Reset mid-operation discards staged, queued and outstanding work. The hyperbolic core shares resetn.
  - hc_resp_valid arriving while no entry is pending is ignored.
- Stage register (stage_x, stage_v, stage_first, stage_region):
  - Loaded at each accepted handshake (valid_in && in_ready); stage_first=1 on load.
  - Effective region: region_in when stage_first=1, otherwise stage_region.
  - region_in is captured into stage_region on the first stage cycle if the stage does not complete that cycle; stage_first then clears.
- stage_done = stage_v && (region==11 || (count<DEPTH && (region!=00 || hc_req_ready))).
- in_ready = !stage_v || stage_done. This is a combinational path from hc_req_ready and region_in.
- On stage completion, by region:
  - 01: write entry {ready, y = sign(stage_x) ? 32'hBF800000 : 32'h3F800000, region 01}.
  - 10: write entry {ready, y = stage_x, region 10}.
  - 00: hc_req_valid = stage_v && region==00 && count<DEPTH; hc_x = stage_x. On the handshake, write entry {pending, region 00}.
  - 11: no entry is written; drop_count increments unless it is already all-ones.
- Response fill:
  - pend_ptr points to the oldest pending entry.
  - On hc_resp_valid, that entry gets data = hc_resp_y and is marked ready; pend_ptr advances.
  - Capacity is guaranteed because each request owns an allocated entry.
- Output:
  - y_valid = count>0 && head entry ready; y and y_region come from the head entry.
  - The head pops on y_valid && y_ready.
  - A pending head blocks output (head-of-line blocking), preserving order.
- Count and pointers:
  - Write and pop in the same cycle leave count unchanged.
  - Space uses the registered count only; there is no full-FIFO pass-through.
  - Pointers wrap modulo DEPTH.
- Latency, non-hyperbolic: x accepted at cycle N, entry written at end of N+1, y_valid at N+2 if the FIFO is ahead-empty.
- Latency, hyperbolic: hc request at N+1 at the earliest; y_valid the cycle after the response.
- Simultaneous events: a response fill and a pop never target the same entry. A response fill and a stage write in the same cycle are both performed.

Optional Feature:
TANH_ODD_SYM_EN:
- Defined:
  - hc_x = {1'b0, stage_x[30:0]}.
  - Each entry stores the sign of stage_x.
  - On fill, y = {stored_sign ^ hc_resp_y[31], hc_resp_y[30:0]}, i.e. the core only evaluates |x|.
- Undefined:
  - hc_x = stage_x and y = hc_resp_y unchanged; no sign storage.

Test Plan:
- x=32'h41200000 (10.0), region_in=01 one cycle later, y_ready=1 -> y=32'h3F800000, y_region=01, y_valid two cycles after acceptance; x=32'hC1200000 -> y=32'hBF800000.
- x=32'h3C23D70A (0.01), region 10 -> y=32'h3C23D70A; region 11 sample -> no output, drop_count increments 0->1; drop_count saturation check at CNT_W=2 (stays 3).
- Hyperbolic x=32'h3F000000 (0.5), region 00, core returns 32'h3EEC9A9E after 5 cycles -> single hc handshake with hc_x=32'h3F000000; y=32'h3EEC9A9E.
- Order check: hyperbolic A (core latency 6), linear B, saturation C -> y order A, B, C; B and C held until A fills.
- Backpressure: y_ready=0, with the stream chosen to fill DEPTH=4 FIFO entries -> in_ready drops after the stage fills; hc_req_ready=0 with a hyperbolic stage -> region latched, in_ready=0, correct y after release; no loss.
- With TANH_ODD_SYM_EN: x=32'hBF000000, region 00 -> hc_x=32'h3F000000; core returns 32'h3EEC9A9E -> y=32'hBEEC9A9E. Assert resetn=0 mid-stream -> y_valid=0, drop_count=0 next cycle.
